// File: rtl/naive_bus_arb_pkg.sv
// Shared types and constants for the two-master naive_bus arbiter.
//   ADDR_W/DATA_W/BE_W : naive_bus field widths
//   ARB_RR/ARB_FIXED   : values of the arbiter ARB_MODE parameter
//   owner_t            : which master owns the read data returning this cycle
//   sel_t              : arbiter selection (which master drives the shared target)
package naive_bus_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    typedef enum logic {
        SEL_M0 = 1'b0,
        SEL_M1 = 1'b1
    } sel_t;

endpackage

// File: rtl/naive_bus_arbiter2_if.sv
// naive_bus: simple request/grant bus with independent read and write channels.
//   master modport : drives rd_req/rd_addr and wr_req/wr_addr/wr_data/wr_be,
//                    receives rd_gnt, wr_gnt and rd_data (one cycle after the read grant)
//   slave modport  : the mirror image
interface naive_bus;
    import naive_bus_arb_pkg::*;

    logic              rd_req;
    logic              rd_gnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    logic              wr_req;
    logic              wr_gnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        output rd_gnt, rd_data, wr_gnt
    );

endinterface

// File: rtl/naive_bus_arbiter2_rr_arb2.sv
// rr_arb2: 2-way arbiter for one bus channel.
//   clk, rst_n : clock, synchronous active-low reset
//   req_i[1:0] : request from master 1 (bit 1) and master 0 (bit 0)
//   hs_i       : the selected request completed a handshake this cycle
//   mode_i     : 0 = round-robin, 1 = fixed priority (master 0 wins)
//   sel_o      : selected master (combinational)
//   oh_o[1:0]  : one-hot selected request, zero when nobody requests (combinational)
module rr_arb2
    import naive_bus_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       hs_i,
    input  logic       mode_i,
    output sel_t       sel_o,
    output logic [1:0] oh_o
);

    sel_t last_q;
    sel_t last_d;

    // Selection: a lone requester always wins; on contention either m0 (fixed)
    // or the master that was not granted last (round-robin).
    always_comb begin
        sel_o = SEL_M0;
        case (req_i)
            2'b01:   sel_o = SEL_M0;
            2'b10:   sel_o = SEL_M1;
            2'b11:   sel_o = mode_i ? SEL_M0 : ((last_q == SEL_M0) ? SEL_M1 : SEL_M0);
            default: sel_o = SEL_M0;
        endcase
    end

    assign oh_o = req_i & ((sel_o == SEL_M1) ? 2'b10 : 2'b01);

    // Pointer moves only on a completed handshake; stalls keep the old owner.
    always_comb begin
        last_d = last_q;
        if (hs_i) begin
            last_d = sel_o;
        end
    end

    // Reset to M1 so that m0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= SEL_M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/naive_bus_arbiter2.sv
// naive_bus_arbiter2: shares one naive_bus target between two masters.
//   ARB_MODE : ARB_RR (round-robin) or ARB_FIXED (m0 highest priority)
//   clk      : clock
//   rst_n    : synchronous active-low reset
//   m0       : requester 0 (instruction fetch), slave side
//   m1       : requester 1 (debug/loader), slave side
//   s        : shared target (ROM/RAM), master side
// Read and write channels are arbitrated independently and combinationally;
// read data returns one cycle after the read handshake and is steered to the
// master recorded in rd_owner_q.
module naive_bus_arbiter2
    import naive_bus_arb_pkg::*;
#(
    parameter int unsigned ARB_MODE = ARB_RR
) (
    input  logic      clk,
    input  logic      rst_n,
    naive_bus.slave   m0,
    naive_bus.slave   m1,
    naive_bus.master  s
);

    localparam logic MODE_FIXED = 1'(ARB_MODE == ARB_FIXED);

    sel_t       rd_sel;
    sel_t       wr_sel;
    logic [1:0] rd_oh;
    logic [1:0] wr_oh;
    logic       rd_any;
    logic       wr_any;
    logic       rd_hs;
    logic       wr_hs;

    owner_t     rd_owner_q;
    owner_t     rd_owner_d;

    // Per-channel arbiters, each with its own priority pointer.
    rr_arb2 u_rd_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  ({m1.rd_req, m0.rd_req}),
        .hs_i   (rd_hs),
        .mode_i (MODE_FIXED),
        .sel_o  (rd_sel),
        .oh_o   (rd_oh)
    );

    rr_arb2 u_wr_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  ({m1.wr_req, m0.wr_req}),
        .hs_i   (wr_hs),
        .mode_i (MODE_FIXED),
        .sel_o  (wr_sel),
        .oh_o   (wr_oh)
    );

    assign rd_any = |rd_oh;
    assign wr_any = |wr_oh;
    assign rd_hs  = rd_any & s.rd_gnt;
    assign wr_hs  = wr_any & s.wr_gnt;

    // Target side: only the selected master's fields pass; all-zero when idle.
    assign s.rd_req  = rd_any;
    assign s.rd_addr = rd_any ? ((rd_sel == SEL_M1) ? m1.rd_addr : m0.rd_addr) : '0;

    assign s.wr_req  = wr_any;
    assign s.wr_addr = wr_any ? ((wr_sel == SEL_M1) ? m1.wr_addr : m0.wr_addr) : '0;
    assign s.wr_data = wr_any ? ((wr_sel == SEL_M1) ? m1.wr_data : m0.wr_data) : '0;
    assign s.wr_be   = wr_any ? ((wr_sel == SEL_M1) ? m1.wr_be   : m0.wr_be)   : '0;

    // Grants reach only the selected, requesting master.
    assign m0.rd_gnt = s.rd_gnt & rd_oh[0];
    assign m1.rd_gnt = s.rd_gnt & rd_oh[1];
    assign m0.wr_gnt = s.wr_gnt & wr_oh[0];
    assign m1.wr_gnt = s.wr_gnt & wr_oh[1];

    // Owner of next cycle's read data; cleared whenever no read handshake.
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (rd_hs) begin
            rd_owner_d = (rd_sel == SEL_M1) ? OWN_M1 : OWN_M0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0.rd_data = (rd_owner_q == OWN_M0) ? s.rd_data : '0;
    assign m1.rd_data = (rd_owner_q == OWN_M1) ? s.rd_data : '0;

endmodule

// File: tb/tb_naive_bus_arbiter2.sv
// Self-checking bench for naive_bus_arbiter2: one round-robin and one
// fixed-priority instance driven by identical master stimulus. Read-return
// expectations are queued at the handshake and popped the following cycle.
module tb_naive_bus_arbiter2;
    import naive_bus_arb_pkg::*;

    typedef struct packed {
        logic        s_rd_req;
        logic [31:0] s_rd_addr;
        logic        s_wr_req;
        logic [31:0] s_wr_addr;
        logic [31:0] s_wr_data;
        logic [3:0]  s_wr_be;
        logic        m0_rd_gnt;
        logic        m1_rd_gnt;
        logic        m0_wr_gnt;
        logic        m1_wr_gnt;
        logic [31:0] m0_rd_data;
        logic [31:0] m1_rd_data;
    } obs_t;

    typedef struct packed {
        logic [1:0]  own;   // 0 none, 1 m0, 2 m1
        logic [31:0] data;
    } rexp_t;

    logic        clk;
    logic        rst_n;
    logic        m0_rd_req, m1_rd_req, m0_wr_req, m1_wr_req;
    logic [31:0] m0_rd_addr, m1_rd_addr, m0_wr_addr, m1_wr_addr;
    logic [31:0] m0_wr_data, m1_wr_data;
    logic [3:0]  m0_wr_be, m1_wr_be;
    logic        s_rd_gnt, s_wr_gnt;
    logic [31:0] s_rd_data  [2];
    logic [31:0] next_rdata [2];

    int    n_pass = 0;
    int    n_chk  = 0;
    int    cur_g  = 0;
    int    cyc    = 0;
    int    last_rd [2];
    int    last_wr [2];
    rexp_t rq0 [$];
    rexp_t rq1 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        naive_bus m0_bus ();
        naive_bus m1_bus ();
        naive_bus s_bus ();
        obs_t     obs;

        assign m0_bus.rd_req  = m0_rd_req;
        assign m0_bus.rd_addr = m0_rd_addr;
        assign m0_bus.wr_req  = m0_wr_req;
        assign m0_bus.wr_addr = m0_wr_addr;
        assign m0_bus.wr_data = m0_wr_data;
        assign m0_bus.wr_be   = m0_wr_be;
        assign m1_bus.rd_req  = m1_rd_req;
        assign m1_bus.rd_addr = m1_rd_addr;
        assign m1_bus.wr_req  = m1_wr_req;
        assign m1_bus.wr_addr = m1_wr_addr;
        assign m1_bus.wr_data = m1_wr_data;
        assign m1_bus.wr_be   = m1_wr_be;
        assign s_bus.rd_gnt   = s_rd_gnt;
        assign s_bus.wr_gnt   = s_wr_gnt;
        assign s_bus.rd_data  = s_rd_data[g];

        naive_bus_arbiter2 #(.ARB_MODE(g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .m0    (m0_bus),
            .m1    (m1_bus),
            .s     (s_bus)
        );

        assign obs = '{s_rd_req:   s_bus.rd_req,   s_rd_addr:  s_bus.rd_addr,
                       s_wr_req:   s_bus.wr_req,   s_wr_addr:  s_bus.wr_addr,
                       s_wr_data:  s_bus.wr_data,  s_wr_be:    s_bus.wr_be,
                       m0_rd_gnt:  m0_bus.rd_gnt,  m1_rd_gnt:  m1_bus.rd_gnt,
                       m0_wr_gnt:  m0_bus.wr_gnt,  m1_wr_gnt:  m1_bus.wr_gnt,
                       m0_rd_data: m0_bus.rd_data, m1_rd_data: m1_bus.rd_data};
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (mode %0d, cycle %0d): got 0x%08h, want 0x%08h",
                     tag, cur_g, cyc, act, exp);
        end
    endtask

    task automatic dchk(input int g, input string tag, input logic [31:0] act, input logic [31:0] exp);
        cur_g = g;
        check_eq(tag, act, exp);
    endtask

    // Target ROM contents returned one cycle after a read handshake.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 32'h4005_0113;
            32'h0000_0008: return 32'h0005_0513;
            default:       return {a[15:0], 16'hC0DE} ^ 32'h1234_0000;
        endcase
    endfunction

    // Expected selection: -1 none, 0 m0, 1 m1.
    function automatic int exp_sel(input logic r0, input logic r1, input int mode, input int last);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (r0 && r1)  return (mode == 1) ? 0 : ((last == 0) ? 1 : 0);
        return -1;
    endfunction

    task automatic eval_dut(input int g, input obs_t o);
        rexp_t       e;
        int          rs;
        int          ws;
        logic [31:0] ra;
        cur_g = g;
        e = '0;
        if (g == 0) begin
            if (rq0.size() > 0) e = rq0.pop_front();
        end else begin
            if (rq1.size() > 0) e = rq1.pop_front();
        end
        check_eq("m0.rd_data", o.m0_rd_data, (e.own == 2'd1) ? e.data : 32'h0);
        check_eq("m1.rd_data", o.m1_rd_data, (e.own == 2'd2) ? e.data : 32'h0);

        rs = exp_sel(m0_rd_req, m1_rd_req, g, last_rd[g]);
        ws = exp_sel(m0_wr_req, m1_wr_req, g, last_wr[g]);
        ra = (rs == 0) ? m0_rd_addr : (rs == 1) ? m1_rd_addr : 32'h0;

        check_eq("s.rd_req",  32'(o.s_rd_req),  32'(rs >= 0));
        check_eq("s.rd_addr", o.s_rd_addr, ra);
        check_eq("m0.rd_gnt", 32'(o.m0_rd_gnt), 32'(s_rd_gnt && rs == 0));
        check_eq("m1.rd_gnt", 32'(o.m1_rd_gnt), 32'(s_rd_gnt && rs == 1));
        check_eq("s.wr_req",  32'(o.s_wr_req),  32'(ws >= 0));
        check_eq("s.wr_addr", o.s_wr_addr, (ws == 0) ? m0_wr_addr : (ws == 1) ? m1_wr_addr : 32'h0);
        check_eq("s.wr_data", o.s_wr_data, (ws == 0) ? m0_wr_data : (ws == 1) ? m1_wr_data : 32'h0);
        check_eq("s.wr_be",   32'(o.s_wr_be),
                 32'((ws == 0) ? m0_wr_be : (ws == 1) ? m1_wr_be : 4'h0));
        check_eq("m0.wr_gnt", 32'(o.m0_wr_gnt), 32'(s_wr_gnt && ws == 0));
        check_eq("m1.wr_gnt", 32'(o.m1_wr_gnt), 32'(s_wr_gnt && ws == 1));

        // Next-cycle return: data only for a handshake not cancelled by reset.
        if (rst_n && s_rd_gnt && rs >= 0) begin
            e.own  = 2'(rs + 1);
            e.data = rom(ra);
            next_rdata[g] = rom(ra);
        end else begin
            e = '0;
            next_rdata[g] = 32'hBAD0_0000 | 32'(cyc);
        end
        if (g == 0) rq0.push_back(e);
        else        rq1.push_back(e);

        if (!rst_n) begin
            last_rd[g] = 1;
            last_wr[g] = 1;
        end else begin
            if (s_rd_gnt && rs >= 0) last_rd[g] = rs;
            if (s_wr_gnt && ws >= 0) last_wr[g] = ws;
        end
    endtask

    task automatic mid();
        s_rd_data[0] = next_rdata[0];
        s_rd_data[1] = next_rdata[1];
        #4;
        eval_dut(0, g_dut[0].obs);
        eval_dut(1, g_dut[1].obs);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        mid();
        step();
    endtask

    task automatic idle();
        m0_rd_req = 0; m1_rd_req = 0; m0_wr_req = 0; m1_wr_req = 0;
        m0_rd_addr = 0; m1_rd_addr = 0; m0_wr_addr = 0; m1_wr_addr = 0;
        m0_wr_data = 0; m1_wr_data = 0; m0_wr_be = 0; m1_wr_be = 0;
        s_rd_gnt = 0; s_wr_gnt = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        cycle();
        cycle();
        rst_n = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        next_rdata[0] = 32'h0; next_rdata[1] = 32'h0;
        s_rd_data[0]  = 32'h0; s_rd_data[1]  = 32'h0;
        last_rd[0] = 1; last_rd[1] = 1; last_wr[0] = 1; last_wr[1] = 1;
        step();
        do_reset();

        // Idle bus with non-zero but unrequested master fields.
        idle();
        m0_rd_addr = 32'h1234; m1_wr_addr = 32'h5678; m1_wr_data = 32'hFFFF_0000; m0_wr_be = 4'hA;
        s_rd_gnt = 1; s_wr_gnt = 1;
        cycle();

        // Single read by m0 from 0x04.
        idle();
        m0_rd_req = 1; m0_rd_addr = 32'h4; s_rd_gnt = 1;
        mid();
        dchk(0, "single m0.rd_gnt", 32'(g_dut[0].obs.m0_rd_gnt), 32'h1);
        dchk(0, "single s.rd_addr", g_dut[0].obs.s_rd_addr, 32'h4);
        step();
        idle();
        mid();
        dchk(0, "single m0.rd_data", g_dut[0].obs.m0_rd_data, 32'h4005_0113);
        dchk(0, "single m1.rd_data", g_dut[0].obs.m1_rd_data, 32'h0);
        step();

        // Continuous contention for 4 cycles from reset.
        do_reset();
        m0_rd_req = 1; m1_rd_req = 1; s_rd_gnt = 1;
        for (int i = 0; i < 4; i++) begin
            m0_rd_addr = 32'h100 + 32'(4 * i);
            m1_rd_addr = 32'h200 + 32'(4 * i);
            mid();
            dchk(0, "rr m0.rd_gnt",    32'(g_dut[0].obs.m0_rd_gnt), 32'(i % 2 == 0));
            dchk(0, "rr m1.rd_gnt",    32'(g_dut[0].obs.m1_rd_gnt), 32'(i % 2 == 1));
            dchk(1, "fixed m0.rd_gnt", 32'(g_dut[1].obs.m0_rd_gnt), 32'h1);
            dchk(1, "fixed m1.rd_gnt", 32'(g_dut[1].obs.m1_rd_gnt), 32'h0);
            step();
        end
        idle();
        mid();
        dchk(0, "rr last return m1", g_dut[0].obs.m1_rd_data, rom(32'h20C));
        dchk(1, "fixed last return m0", g_dut[1].obs.m0_rd_data, rom(32'h10C));
        step();

        // Stall with both requesting after m0 was last granted.
        idle();
        m0_rd_req = 1; m0_rd_addr = 32'h40; s_rd_gnt = 1;
        cycle();
        m1_rd_req = 1; m1_rd_addr = 32'h80; s_rd_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            mid();
            dchk(0, "stall m0.rd_gnt", 32'(g_dut[0].obs.m0_rd_gnt), 32'h0);
            dchk(0, "stall m1.rd_gnt", 32'(g_dut[0].obs.m1_rd_gnt), 32'h0);
            step();
        end
        s_rd_gnt = 1;
        mid();
        dchk(0, "release rr m1.rd_gnt",    32'(g_dut[0].obs.m1_rd_gnt), 32'h1);
        dchk(1, "release fixed m0.rd_gnt", 32'(g_dut[1].obs.m0_rd_gnt), 32'h1);
        step();
        idle();
        cycle();

        // Concurrent read by m0 and write by m1.
        idle();
        m0_rd_req = 1; m0_rd_addr = 32'h8; s_rd_gnt = 1;
        m1_wr_req = 1; m1_wr_addr = 32'h100; m1_wr_data = 32'hDEAD_BEEF; m1_wr_be = 4'hF; s_wr_gnt = 1;
        mid();
        dchk(0, "rdwr s.wr_data", g_dut[0].obs.s_wr_data, 32'hDEAD_BEEF);
        dchk(0, "rdwr m1.wr_gnt", 32'(g_dut[0].obs.m1_wr_gnt), 32'h1);
        dchk(0, "rdwr m0.rd_gnt", 32'(g_dut[0].obs.m0_rd_gnt), 32'h1);
        step();
        idle();
        mid();
        dchk(0, "rdwr m0.rd_data", g_dut[0].obs.m0_rd_data, 32'h0005_0513);
        step();

        // Write contention with alternating payloads.
        idle();
        m0_wr_req = 1; m1_wr_req = 1; s_wr_gnt = 1;
        for (int i = 0; i < 4; i++) begin
            m0_wr_addr = 32'h300 + 32'(i); m0_wr_data = 32'hA000_0000 + 32'(i); m0_wr_be = 4'h3;
            m1_wr_addr = 32'h400 + 32'(i); m1_wr_data = 32'hB000_0000 + 32'(i); m1_wr_be = 4'hC;
            cycle();
        end

        // Reset around outstanding reads.
        idle();
        m0_rd_req = 1; m0_rd_addr = 32'h4; s_rd_gnt = 1;
        cycle();
        rst_n = 0;
        m0_rd_addr = 32'h8;
        mid();
        dchk(0, "reset m0.rd_gnt comb", 32'(g_dut[0].obs.m0_rd_gnt), 32'h1);
        step();
        idle();
        mid();
        dchk(0, "reset drop m0.rd_data", g_dut[0].obs.m0_rd_data, 32'h0);
        dchk(0, "reset drop m1.rd_data", g_dut[0].obs.m1_rd_data, 32'h0);
        step();
        rst_n = 1;
        m0_rd_req = 1; m1_rd_req = 1; m0_rd_addr = 32'h10; m1_rd_addr = 32'h20; s_rd_gnt = 1;
        mid();
        dchk(0, "post-reset m0 wins", 32'(g_dut[0].obs.m0_rd_gnt), 32'h1);
        step();

        // Random traffic.
        for (int i = 0; i < 120; i++) begin
            rst_n      = ($urandom_range(0, 15) != 0);
            m0_rd_req  = 1'($urandom_range(0, 1));
            m1_rd_req  = 1'($urandom_range(0, 1));
            m0_wr_req  = 1'($urandom_range(0, 1));
            m1_wr_req  = 1'($urandom_range(0, 1));
            m0_rd_addr = $urandom() & 32'hFFFF_FFFC;
            m1_rd_addr = $urandom() & 32'hFFFF_FFFC;
            m0_wr_addr = $urandom() & 32'hFFFF_FFFC;
            m1_wr_addr = $urandom() & 32'hFFFF_FFFC;
            m0_wr_data = $urandom();
            m1_wr_data = $urandom();
            m0_wr_be   = 4'($urandom_range(0, 15));
            m1_wr_be   = 4'($urandom_range(0, 15));
            s_rd_gnt   = ($urandom_range(0, 3) != 0);
            s_wr_gnt   = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst_n = 1;
        idle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/naive_bus_arbiter2.md
NAIVE_BUS_ARBITER2 -- requirements
Module: naive_bus_arbiter2

Interface
REQ-001 The block SHALL have parameter ARB_MODE, default 0; 0 = round-robin, 1 = fixed priority with m0 highest.
REQ-002 The block SHALL have port clk, input, 1 bit; the single clock for all state.
REQ-003 The block SHALL have port rst_n, input, 1 bit; the reset, synchronous and active-low.
REQ-004 The block SHALL have port m0, naive_bus.slave, 1 bit each: rd_req, rd_gnt, wr_req, wr_gnt; 32 bits each: rd_addr, rd_data, wr_addr, wr_data; 4 bits: wr_be; it is requester 0 (instruction fetch).
REQ-005 The block SHALL have port m1, naive_bus.slave with the same fields as m0; it is requester 1 (debug/loader).
REQ-006 The block SHALL have port s, naive_bus.master; the shared target (instruction ROM or RAM).

Function
REQ-007 Read and write channels SHALL be arbitrated independently, each with its own priority pointer.
REQ-008 Grant is combinational: s.rd_req = OR of masked master rd_req; s.rd_addr = rd_addr of the selected master; the same applies to wr_req, wr_addr, wr_data and wr_be.
REQ-009 Master rd_gnt SHALL equal s.rd_gnt AND (selected == that master); an unselected master sees rd_gnt=0. The same rule applies to wr_gnt.
REQ-010 Single requester: it is selected regardless of pointer or mode.
REQ-011 Both requesting, ARB_MODE=0: select the master other than last_rd (or last_wr); ARB_MODE=1: always select m0.
REQ-012 last_rd and last_wr SHALL update only on a completed handshake (req & gnt); a stalled request (s gnt=0) leaves the pointer unchanged.
REQ-013 Read return: on a read handshake, register rd_owner ∈ {NONE, M0, M1}; with no read handshake, rd_owner := NONE.
REQ-014 In the cycle after the handshake, the owner's rd_data SHALL equal s.rd_data; the non-owner's rd_data SHALL be 0; with rd_owner=NONE, both SHALL be 0.
REQ-015 Back-to-back reads (handshake on every cycle, possibly alternating masters) SHALL sustain one read per cycle with correct routing.
REQ-016 Simultaneous read and write handshakes by different masters in the same cycle SHALL both be passed to s without interference.
REQ-017 When neither master requests, s.rd_req=0, s.wr_req=0, and all s address/data/be outputs = 0.
REQ-018 Unselected master signals SHALL never reach s.

Reset
REQ-019 When rst_n=0 at a clk edge: rd_owner := NONE; last_rd := M1; last_wr := M1 (so m0 wins the first contention).
REQ-020 Reset asserted with a read outstanding SHALL drop the return data; both masters see rd_data=0 in the following cycle.
REQ-021 During reset, gnt outputs SHALL follow combinational rules, but no pointer or owner update occurs.

Structure
REQ-022 Shared package naive_bus_arb_pkg SHALL hold the enum owner_t {OWN_NONE, OWN_M0, OWN_M1} and the constants ARB_RR=0 and ARB_FIXED=1.
REQ-023 Sub-module rr_arb2 (2-way arbiter: req[1:0], hs, mode → sel, last pointer register) SHALL be instantiated once per channel.
REQ-024 Read-data routing and the rd_owner register SHALL live in the top module.

Verification
REQ-025 m0 reads 0x04 alone, s.rd_gnt=1 → m0.rd_gnt=1, s.rd_addr=0x04; next cycle m0.rd_data=s.rd_data (0x40050113), m1.rd_data=0.
REQ-026 Both masters read continuously for 4 cycles, ARB_MODE=0 → grants m0,m1,m0,m1; each data word returns to the correct master one cycle later.
REQ-027 Same stimulus with ARB_MODE=1 → m0 granted all 4 cycles, m1.rd_gnt=0 throughout.
REQ-028 s.rd_gnt held 0 for 3 cycles while both request → no master gnt, pointer unchanged; first grant on release goes to the master not last granted.
REQ-029 m0 reads 0x08 while m1 writes 0x100/0xDEADBEEF/be=0xF in the same cycle → both handshake; s.wr_data=0xDEADBEEF; m0 receives 0x00050513.
REQ-030 rst_n=0 in the cycle after a read handshake → both rd_data=0; after release, first contention grants m0.
